// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between an instruction-fetch master and a data
//   (load/store) master. Only one transaction is on the memory port at a
//   time. When both masters request, data has priority. A waiting fetch
//   cannot be starved indefinitely: after STARVE_LIMIT data grants that
//   each overtook it, the fetch gets the next slot.
//
// Ports
//   clk, reset            single clock, asynchronous active-high reset
//   i_req, i_addr         fetch request (held until i_ready)
//   i_rdata, i_ready      fetch data and one-cycle completion pulse
//   d_req, d_we, d_size,  data request (held until d_ready)
//   d_addr, d_wdata
//   d_rdata, d_ready      load data and one-cycle completion pulse
//   m_valid, m_we,        registered memory transaction
//   m_size, m_addr, m_wdata
//   m_rdata, m_ack        memory read data and completion
//   busy                  high whenever the arbiter is not idle
//
// State | meaning
// IDLE  | no transaction; pending requests are arbitrated here
// IBUSY | fetch on the memory port, waiting for m_ack
// DBUSY | load/store on the memory port, waiting for m_ack
// RESP  | one-cycle ready pulse to the master that was served
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_valid,
  output logic        m_we,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arbState_t  state;
  arbState_t  stateNext;
  logic [3:0] starveCnt;
  logic       starveHit;
  logic       dataWins;
  logic       grantData;
  logic       grantInstr;
  logic       ackTaken;

  assign starveHit = (starveCnt == STARVE_MAX);

  // Data has priority unless the waiting fetch has already been overtaken
  // STARVE_LIMIT times in a row.
  assign dataWins = d_req && !(i_req && starveHit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    grantData  = 1'b0;
    grantInstr = 1'b0;
    ackTaken   = 1'b0;
    case (state)
      IDLE: begin
        if (dataWins) begin
          grantData = 1'b1;
          stateNext = DBUSY;
        end else if (i_req) begin
          grantInstr = 1'b1;
          stateNext  = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (m_ack) begin
          ackTaken  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Counts data grants that overtook a pending fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= 4'd0;
    end else if (grantData) begin
      if (!i_req)         starveCnt <= 4'd0;
      else if (!starveHit) starveCnt <= starveCnt + 4'd1;
    end else if (grantInstr) begin
      starveCnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_size  <= 3'd0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      busy    <= (stateNext != IDLE);

      if (grantData) begin
        m_valid <= 1'b1;
        m_we    <= d_we;
        m_size  <= d_size;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grantInstr) begin
        m_valid <= 1'b1;
        m_we    <= 1'b0;
        m_size  <= 3'b010;
        m_addr  <= i_addr;
        m_wdata <= 32'd0;
      end

      // m_* fields other than m_valid keep the last transaction afterwards.
      if (ackTaken) begin
        m_valid <= 1'b0;
        if (state == IBUSY) begin
          i_rdata <= m_rdata;
          i_ready <= 1'b1;
        end else begin
          d_ready <= 1'b1;
          if (!m_we) d_rdata <= m_rdata;
        end
      end
    end
  end

endmodule
